pio_irq_servicer: RTL



---
 rtl/pio_irq_servicer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pio_irq_servicer.sv
// Purpose: Avalon-MM initiator that programs a 7-bit interrupt PIO's irq mask,
//          services its level irq by reading the data register, and hands each
//          nonzero masked snapshot to the consumer as a valid/ready event.
// Ports:   clk/reset (sync, active-high); avm_* initiator bus to the PIO;
//          pio_irq level irq in; mask_cfg/cfg_load/rearm mask control;
//          evt_valid/evt_ready/evt_data event out; cur_mask shadow mask.
// Latency: irq seen in IDLE at cycle N -> evt_valid at N+3.
// Backpressure: one event outstanding; bus stays idle until evt_ready.
module pio_irq_servicer #(
  parameter int WIDTH       = 7,
  parameter int DATA_ADDR   = 0,
  parameter int MASK_ADDR   = 2,
  parameter int AUTO_DISARM = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             pio_irq,
  input  logic [WIDTH-1:0] mask_cfg,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] rearm,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic [WIDTH-1:0] cur_mask
);

  localparam logic [1:0] DATA_A = DATA_ADDR[1:0];
  localparam logic [1:0] MASK_A = MASK_ADDR[1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_MASK,
    S_RD_ADDR,
    S_RD_CAP,
    S_PRESENT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic             mask_dirty;
  logic [WIDTH-1:0] captured;
  logic [WIDTH-1:0] shadow_nxt;
  logic             mask_upd;

  // Only the PIO-width low bits of readdata carry information.
  logic unused_rd;
  assign unused_rd = ^avm_readdata[31:WIDTH];

  assign cur_mask = shadow;

  // Next shadow mask: load, then rearm, then (in RD_CAP) auto-disarm of the
  // bits just serviced, so a disarm wins over a same-cycle rearm of that bit.
  always_comb begin
    captured   = avm_readdata[WIDTH-1:0] & shadow;
    shadow_nxt = (cfg_load ? mask_cfg : shadow) | rearm;
    mask_upd   = cfg_load | (|rearm);
    if (AUTO_DISARM != 0 && state == S_RD_CAP && captured != '0) begin
      shadow_nxt = shadow_nxt & ~captured;
      mask_upd   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      shadow         <= '0;
      mask_dirty     <= 1'b1;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= DATA_A;
      avm_writedata  <= '0;
      evt_valid      <= 1'b0;
      evt_data       <= '0;
    end else begin
      shadow <= shadow_nxt;
      // The write in progress carries the current shadow; only an update
      // arriving during that write leaves the mask dirty.
      mask_dirty <= (state == S_WR_MASK) ? mask_upd : (mask_dirty | mask_upd);

      // Bus returns to idle unless the transition below starts a cycle.
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= DATA_A;

      case (state)
        S_IDLE: begin
          // A same-cycle mask update also beats a pending irq.
          if (mask_dirty || mask_upd) begin
            state          <= S_WR_MASK;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= MASK_A;
            avm_writedata  <= {{(32-WIDTH){1'b0}}, shadow_nxt};
          end else if (pio_irq) begin
            state          <= S_RD_ADDR;
            avm_chipselect <= 1'b1;
          end
        end
        S_WR_MASK: state <= S_IDLE;
        // Responder registers readdata from this cycle's address.
        S_RD_ADDR: state <= S_RD_CAP;
        S_RD_CAP: begin
          if (captured != '0) begin
            evt_data  <= captured;
            evt_valid <= 1'b1;
            state     <= S_PRESENT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PRESENT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
